// File: rtl/fitness_eval.sv
// fitness_eval: scores a latched population against a target, one
// chromosome per cycle; reports best index/fitness and the fitness sum.
// Ports: clk, rst_n (async active-low), start, population, target in;
//        busy, done, best_index, best_fitness, fitness_sum out.
module fitness_eval #(
  parameter int NUM_IND = 100,
  parameter int CHROM_W = 75,
  parameter int GENE_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_IND*CHROM_W-1:0] population,
  input  logic [CHROM_W-1:0]         target,
  output logic                       busy,
  output logic                       done,
  output logic [6:0]                 best_index,
  output logic [4:0]                 best_fitness,
  output logic [11:0]                fitness_sum
);

  localparam int GENES = CHROM_W / GENE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [6:0] LAST = 7'(NUM_IND - 1);

  logic [1:0]                 state;
  logic [6:0]                 idx;
  logic [11:0]                acc_sum;
  logic [6:0]                 acc_idx;
  logic [4:0]                 acc_fit;
  logic [NUM_IND*CHROM_W-1:0] pop_q;
  logic [CHROM_W-1:0]         tgt_q;

  logic [CHROM_W-1:0] chrom;
  logic [4:0]         fit;
  logic               take;
  logic [11:0]        nxt_sum;
  logic [6:0]         nxt_idx;
  logic [4:0]         nxt_fit;

  assign busy = (state == EVAL);
  assign done = (state == DONE);

  always_comb begin
    chrom = pop_q[int'(idx)*CHROM_W +: CHROM_W];
    fit   = '0;
    for (int g = 0; g < GENES; g++) begin
      if (chrom[g*GENE_W +: GENE_W] == tgt_q[g*GENE_W +: GENE_W])
        fit = fit + 5'd1;
    end
  end

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign take    = fit > acc_fit;
  assign nxt_sum = acc_sum + 12'(fit);
  assign nxt_idx = take ? idx : acc_idx;
  assign nxt_fit = take ? fit : acc_fit;

  // Working copies only; never cleared by reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      pop_q <= population;
      tgt_q <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      acc_sum      <= '0;
      acc_idx      <= '0;
      acc_fit      <= '0;
      best_index   <= '0;
      best_fitness <= '0;
      fitness_sum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= EVAL;
            idx     <= '0;
            acc_sum <= '0;
            acc_idx <= '0;
            acc_fit <= '0;
          end
        end
        EVAL: begin
          acc_sum <= nxt_sum;
          acc_idx <= nxt_idx;
          acc_fit <= nxt_fit;
          idx     <= idx + 7'd1;
          if (idx == LAST) begin
            state        <= DONE;
            best_index   <= nxt_idx;
            best_fitness <= nxt_fit;
            fitness_sum  <= nxt_sum;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
